scpu_rom_loader: RTL and testbench
==================================

Name: scpu_rom_loader

Overview:
- Sequences the sound-CPU program ROM (8-bit, 8 KB RAM-backed) between the 16-bit ioctl download stream and sound-CPU reads.
- Splits each in-window 16-bit download word into two byte writes and back-pressures the host with ioctl_wait.
- Holds the sound CPU in reset during loading, and for a fixed hold after loading, then releases it.
- Sits between the HPS ioctl bus, the sound CPU and the ROM RAM instance.

Parameters:
- BASE, 27'h8000, first ioctl byte address of the ROM window.
- AW, 13, ROM address width; window size is 2**AW bytes.
- RST_HOLD, 16, clk_sys cycles cpu_reset stays high after ioctl_download falls.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download in progress.
- ioctl_addr  in  27  download byte address.
- ioctl_dout  in  16  download word; [7:0] goes to even byte, [15:8] to odd byte.
- ioctl_wr  in  1  one-cycle word write strobe.
- ioctl_wait  out  1  host must hold the next strobe while high.
- cpu_ab  in  16  sound-CPU address bus.
- rom_addr  out  AW  ROM RAM address.
- rom_din  out  8  ROM RAM write data.
- rom_wr  out  1  ROM RAM write enable, active high.
- cpu_reset  out  1  sound-CPU reset.
- load_done  out  1  at least one download has completed since reset.
- rom_sum  out  8  modulo-256 sum of all bytes written in the current or last download.
- overrun  out  1  sticky: strobe arrived while busy.

Behaviour:
- Reset values:
  - state = IDLE
  - ioctl_wait = 0, rom_wr = 0, rom_din = 0
  - cpu_reset = 1, load_done = 0, rom_sum = 0, overrun = 0
  - hold counter = 0
- In window: BASE <= ioctl_addr < BASE + 2**AW. ioctl_addr[0] is ignored, so the word is treated as aligned.
- Word offset off = (ioctl_addr - BASE)[AW-1:0] with bit0 cleared. Latch off and ioctl_dout on an accepted strobe.
- FSM states: IDLE, WR_LO, WR_HI.
  - IDLE -> WR_LO: ioctl_download & ioctl_wr & in window. Latch the word; ioctl_wait goes 1 in the next cycle.
  - WR_LO: rom_wr = 1, rom_addr = off, rom_din = lo byte; rom_sum += lo. -> WR_HI.
  - WR_HI: rom_wr = 1, rom_addr = off | 1, rom_din = hi byte; rom_sum += hi. -> IDLE; ioctl_wait drops in the same cycle as the return to IDLE.
- Timing: a word takes 2 cycles of writes; the earliest next accepted strobe is 3 cycles after the previous one.
- Strobes that are out of window, or that arrive while ioctl_download = 0, are ignored: no wait, no write.
- Strobe while in WR_LO or WR_HI: dropped, overrun set (sticky until reset).
- rom_addr mux:
  - WR_LO/WR_HI: the write address.
  - Otherwise while ioctl_download = 1: the write address is still driven, rom_wr = 0.
  - Otherwise: cpu_ab[AW-1:0].
- Rising edge of ioctl_download: rom_sum cleared, cpu_reset = 1, load_done unchanged.
- Falling edge of ioctl_download:
  - If the FSM is busy, the pending byte writes complete first.
  - The hold counter then loads RST_HOLD-1 and decrements each cycle.
  - cpu_reset falls in the cycle after the counter reaches 0, exactly RST_HOLD cycles after the edge when not busy.
  - load_done goes 1 together with the cpu_reset fall.
- ioctl_download re-asserted during the hold: the hold is aborted, cpu_reset stays 1, and load_done keeps its value.
- Reset mid-word: the write is abandoned, all outputs return to reset values, and the ROM contents are untouched.
- cpu_reset stays 1 after reset until a download completes.
- Word at BASE+2**AW-2 writes the last two bytes, 2**AW-2 and 2**AW-1. BASE+2**AW is out of window.

Decomposition:
- Shared package: state encoding (IDLE, WR_LO, WR_HI) and the default BASE/AW constants for the sound ROM map.
- One natural sub-module: scpu_rst_hold. It takes the download-falling-edge pulse plus a busy flag and produces cpu_reset and load_done via the hold counter.
- The write FSM stays in the top level.

Test Plan:
- Reset, no download -> cpu_reset = 1, load_done = 0, rom_addr follows cpu_ab (cpu_ab = 16'h1234 -> rom_addr = 13'h1234).
- Download, strobe at 27'h8000 with dout = 16'hBEEF -> byte EF written to 0 then BE written to 1 on consecutive cycles; ioctl_wait high for 2 cycles; rom_sum = 8'hAD.
- Strobes at 27'h7FFE, 27'hA000 and 27'h0 -> no rom_wr, no ioctl_wait. Strobe at 27'h9FFE with dout = 16'h0102 -> 8'h02 written to 13'h1FFE, 8'h01 to 13'h1FFF.
- Drop ioctl_download with no write pending -> cpu_reset falls exactly 16 cycles later; load_done rises with it.
- Second strobe one cycle after the first -> overrun = 1, only the first word written.
- Assert reset during WR_LO -> no WR_HI write, all outputs at reset values. Re-raise ioctl_download during the hold -> cpu_reset stays 1.

Source files
------------

// File: rtl/scpu_rom_loader_pkg.sv
// Shared definitions for the sound-CPU program ROM loader: write FSM encoding
// and the default placement of the sound ROM in the ioctl download map.
package scpu_rom_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR_LO = 2'd1,
      WR_HI = 2'd2
   } state_t;

   localparam logic [26:0] SCPU_BASE = 27'h8000;
   localparam int          SCPU_AW   = 13;

endpackage

// File: rtl/scpu_rst_hold.sv
// Keeps the sound CPU in reset while loading and for RST_HOLD cycles after the
// download ends; flags load_done when the CPU is finally released.
module scpu_rst_hold #(
   parameter int RST_HOLD = 16
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic download,
   input  logic dl_fall,
   input  logic busy,
   output logic cpu_reset,
   output logic load_done
);

   localparam int CW = $clog2(RST_HOLD + 1);
   localparam logic [CW-1:0] HOLD_LOAD = CW'(RST_HOLD - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          act_q, act_d;
   logic          pend_q, pend_d;
   logic          cpu_reset_q, cpu_reset_d;
   logic          load_done_q, load_done_d;
   logic          load_s;

   // The counter starts only once the FSM has finished any byte writes still in flight.
   assign load_s = !download && !busy && (dl_fall || pend_q);

   // Hold counter, deferred-start flag and release decision.
   always_comb begin
      cnt_d       = cnt_q;
      act_d       = act_q;
      pend_d      = pend_q;
      cpu_reset_d = cpu_reset_q;
      load_done_d = load_done_q;
      if (download) begin
         act_d       = 1'b0;
         pend_d      = 1'b0;
         cpu_reset_d = 1'b1;
      end else if (load_s) begin
         cnt_d  = HOLD_LOAD;
         act_d  = 1'b1;
         pend_d = 1'b0;
      end else if (dl_fall) begin
         pend_d = 1'b1;
      end else if (act_q && (cnt_q != {CW{1'b0}})) begin
         cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
      if (act_d && (cnt_d == {CW{1'b0}})) begin
         act_d       = 1'b0;
         cpu_reset_d = 1'b0;
         load_done_d = 1'b1;
      end else begin
         act_d = act_d;
      end
   end

   // State registers.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cnt_q       <= {CW{1'b0}};
         act_q       <= 1'b0;
         pend_q      <= 1'b0;
         cpu_reset_q <= 1'b1;
         load_done_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         act_q       <= act_d;
         pend_q      <= pend_d;
         cpu_reset_q <= cpu_reset_d;
         load_done_q <= load_done_d;
      end
   end

   assign cpu_reset = cpu_reset_q;
   assign load_done = load_done_q;

endmodule

// File: rtl/scpu_rom_loader.sv
// Sound-CPU program ROM loader: splits 16-bit ioctl words into byte writes,
// muxes the ROM address between loader and CPU, and sequences CPU reset.
module scpu_rom_loader
   import scpu_rom_loader_pkg::*;
#(
   parameter logic [26:0] BASE     = SCPU_BASE,
   parameter int          AW       = SCPU_AW,
   parameter int          RST_HOLD = 16
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          ioctl_download,
   input  logic [26:0]   ioctl_addr,
   input  logic [15:0]   ioctl_dout,
   input  logic          ioctl_wr,
   output logic          ioctl_wait,
   input  logic [15:0]   cpu_ab,
   output logic [AW-1:0] rom_addr,
   output logic [7:0]    rom_din,
   output logic          rom_wr,
   output logic          cpu_reset,
   output logic          load_done,
   output logic [7:0]    rom_sum,
   output logic          overrun
);

   localparam logic [27:0] WIN_END = {1'b0, BASE} + (28'd1 << AW);

   state_t        state_q, state_d;
   logic [AW-1:0] off_q, off_d;
   logic [15:0]   word_q, word_d;
   logic [7:0]    sum_q, sum_d;
   logic          ovr_q, ovr_d;
   logic          dl_q, dl_d;

   logic          in_win_s;
   logic [AW-1:0] rel_s;
   logic [AW-1:0] off_s;
   logic          dl_rise_s;
   logic          dl_fall_s;
   logic          busy_s;
   logic          unused_cpu_ab;

   assign in_win_s  = (ioctl_addr >= BASE) && ({1'b0, ioctl_addr} < WIN_END);
   assign rel_s     = ioctl_addr[AW-1:0] - BASE[AW-1:0];
   assign off_s     = rel_s & {{(AW-1){1'b1}}, 1'b0};
   assign dl_rise_s = ioctl_download && !dl_q;
   assign dl_fall_s = !ioctl_download && dl_q;
   assign busy_s    = (state_q != IDLE);
   assign unused_cpu_ab = &{1'b0, cpu_ab};
   assign dl_d      = ioctl_download;

   // Write FSM: accept a word, then emit its low and high bytes on successive cycles.
   always_comb begin
      state_d = state_q;
      off_d   = off_q;
      word_d  = word_q;
      ovr_d   = ovr_q;
      if (dl_rise_s) begin
         sum_d = 8'h00;
      end else begin
         sum_d = sum_q;
      end
      case (state_q)
         IDLE: begin
            if (ioctl_download && ioctl_wr && in_win_s) begin
               state_d = WR_LO;
               off_d   = off_s;
               word_d  = ioctl_dout;
            end else begin
               state_d = IDLE;
            end
         end
         WR_LO: begin
            sum_d   = sum_d + word_q[7:0];
            state_d = WR_HI;
            if (ioctl_wr) begin
               ovr_d = 1'b1;
            end else begin
               ovr_d = ovr_q;
            end
         end
         WR_HI: begin
            sum_d   = sum_d + word_q[15:8];
            state_d = IDLE;
            if (ioctl_wr) begin
               ovr_d = 1'b1;
            end else begin
               ovr_d = ovr_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ROM port decode; the CPU owns the address bus only outside a download.
   always_comb begin
      rom_wr   = 1'b0;
      rom_din  = 8'h00;
      rom_addr = off_q;
      case (state_q)
         WR_LO: begin
            rom_wr  = 1'b1;
            rom_din = word_q[7:0];
         end
         WR_HI: begin
            rom_wr   = 1'b1;
            rom_din  = word_q[15:8];
            rom_addr = off_q | {{(AW-1){1'b0}}, 1'b1};
         end
         default: begin
            if (ioctl_download) begin
               rom_addr = off_q;
            end else begin
               rom_addr = cpu_ab[AW-1:0];
            end
         end
      endcase
   end

   // State registers.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= IDLE;
         off_q   <= {AW{1'b0}};
         word_q  <= 16'h0000;
         sum_q   <= 8'h00;
         ovr_q   <= 1'b0;
         dl_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         off_q   <= off_d;
         word_q  <= word_d;
         sum_q   <= sum_d;
         ovr_q   <= ovr_d;
         dl_q    <= dl_d;
      end
   end

   assign ioctl_wait = busy_s;
   assign rom_sum    = sum_q;
   assign overrun    = ovr_q;

   scpu_rst_hold #(
      .RST_HOLD (RST_HOLD)
   ) u_rst_hold (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .download  (ioctl_download),
      .dl_fall   (dl_fall_s),
      .busy      (busy_s),
      .cpu_reset (cpu_reset),
      .load_done (load_done)
   );

endmodule

// File: tb/tb_scpu_rom_loader.sv
// Directed bench for scpu_rom_loader with hand-computed expectations.
module tb_scpu_rom_loader;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ioctl_download;
   logic [26:0] ioctl_addr;
   logic [15:0] ioctl_dout;
   logic        ioctl_wr;
   logic        ioctl_wait;
   logic [15:0] cpu_ab;
   logic [12:0] rom_addr;
   logic [7:0]  rom_din;
   logic        rom_wr;
   logic        cpu_reset;
   logic        load_done;
   logic [7:0]  rom_sum;
   logic        overrun;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk_sys = ~clk_sys;

   scpu_rom_loader dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wr       (ioctl_wr),
      .ioctl_wait     (ioctl_wait),
      .cpu_ab         (cpu_ab),
      .rom_addr       (rom_addr),
      .rom_din        (rom_din),
      .rom_wr         (rom_wr),
      .cpu_reset      (cpu_reset),
      .load_done      (load_done),
      .rom_sum        (rom_sum),
      .overrun        (overrun)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic strobe(input logic [26:0] a, input logic [15:0] d);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      step();
      ioctl_wr   = 1'b0;
   endtask

   initial begin
      logic [26:0] bad_addr [3];
      bad_addr[0] = 27'h7FFE;
      bad_addr[1] = 27'hA000;
      bad_addr[2] = 27'h0;

      reset = 1'b1; ioctl_download = 1'b0; ioctl_addr = 27'h0;
      ioctl_dout = 16'h0; ioctl_wr = 1'b0; cpu_ab = 16'h1234;
      step(); step();
      reset = 1'b0;
      step();
      chk("rst cpu_reset", 32'(cpu_reset), 32'h1);
      chk("rst load_done", 32'(load_done), 32'h0);
      chk("rst rom_addr",  32'(rom_addr),  32'h1234);
      chk("rst wait",      32'(ioctl_wait), 32'h0);
      chk("rst rom_wr",    32'(rom_wr),    32'h0);
      chk("rst rom_din",   32'(rom_din),   32'h0);
      chk("rst rom_sum",   32'(rom_sum),   32'h0);
      chk("rst overrun",   32'(overrun),   32'h0);

      // First word at BASE
      ioctl_download = 1'b1;
      step();
      strobe(27'h8000, 16'hBEEF);
      chk("lo wr",   32'(rom_wr),    32'h1);
      chk("lo addr", 32'(rom_addr),  32'h0);
      chk("lo din",  32'(rom_din),   32'hEF);
      chk("lo wait", 32'(ioctl_wait), 32'h1);
      step();
      chk("hi wr",   32'(rom_wr),    32'h1);
      chk("hi addr", 32'(rom_addr),  32'h1);
      chk("hi din",  32'(rom_din),   32'hBE);
      chk("hi wait", 32'(ioctl_wait), 32'h1);
      step();
      chk("idle wait", 32'(ioctl_wait), 32'h0);
      chk("idle wr",   32'(rom_wr),    32'h0);
      chk("sum BEEF",  32'(rom_sum),   32'hAD);

      // Out-of-window strobes are ignored
      for (int i = 0; i < 3; i++) begin
         strobe(bad_addr[i], 16'hFFFF);
         chk($sformatf("oow wr %0d", i),   32'(rom_wr),    32'h0);
         chk($sformatf("oow wait %0d", i), 32'(ioctl_wait), 32'h0);
      end
      chk("oow sum", 32'(rom_sum), 32'hAD);

      // Last word of the window
      strobe(27'h9FFE, 16'h0102);
      chk("top lo addr", 32'(rom_addr), 32'h1FFE);
      chk("top lo din",  32'(rom_din),  32'h02);
      step();
      chk("top hi addr", 32'(rom_addr), 32'h1FFF);
      chk("top hi din",  32'(rom_din),  32'h01);
      step();
      chk("top sum",       32'(rom_sum),  32'hB0);
      chk("dl idle addr",  32'(rom_addr), 32'h1FFE);
      chk("dl cpu_reset",  32'(cpu_reset), 32'h1);

      // Drop download idle: release exactly 16 cycles later
      ioctl_download = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         step();
         if (k == 15) begin
            chk("hold k15 cpu_reset", 32'(cpu_reset), 32'h1);
            chk("hold k15 load_done", 32'(load_done), 32'h0);
         end else if (k == 16) begin
            chk("hold k16 cpu_reset", 32'(cpu_reset), 32'h0);
            chk("hold k16 load_done", 32'(load_done), 32'h1);
         end
      end
      chk("cpu addr", 32'(rom_addr), 32'h1234);

      // Overrun: second strobe one cycle after the first
      ioctl_download = 1'b1;
      step();
      chk("redl cpu_reset", 32'(cpu_reset), 32'h1);
      chk("redl load_done", 32'(load_done), 32'h1);
      chk("redl sum clr",   32'(rom_sum),   32'h0);
      ioctl_addr = 27'h8010; ioctl_dout = 16'h1122; ioctl_wr = 1'b1;
      step();
      chk("ov lo addr", 32'(rom_addr), 32'h10);
      ioctl_dout = 16'h3344;
      step();
      ioctl_wr = 1'b0;
      chk("ov hi din", 32'(rom_din), 32'h11);
      step();
      chk("ov flag",   32'(overrun), 32'h1);
      chk("ov no wr",  32'(rom_wr),  32'h0);
      step();
      chk("ov no wr2", 32'(rom_wr),  32'h0);
      chk("ov sum",    32'(rom_sum), 32'h33);

      // Download falls while a word is in flight
      strobe(27'h8020, 16'h0000);
      ioctl_download = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         step();
         if (k == 17) chk("busy hold k17", 32'(cpu_reset), 32'h1);
         if (k == 18) chk("busy hold k18", 32'(cpu_reset), 32'h0);
      end

      // Reset during WR_LO
      ioctl_download = 1'b1;
      step();
      strobe(27'h8040, 16'h5566);
      chk("mid wr lo", 32'(rom_wr), 32'h1);
      reset = 1'b1;
      step();
      chk("mid rst wr",     32'(rom_wr),    32'h0);
      chk("mid rst wait",   32'(ioctl_wait), 32'h0);
      chk("mid rst din",    32'(rom_din),   32'h0);
      chk("mid rst cpurst", 32'(cpu_reset), 32'h1);
      chk("mid rst done",   32'(load_done), 32'h0);
      chk("mid rst ov",     32'(overrun),   32'h0);
      chk("mid rst sum",    32'(rom_sum),   32'h0);
      reset = 1'b0;
      step();
      chk("mid rst no hi", 32'(rom_wr), 32'h0);

      // Hold aborted by re-raising download
      ioctl_download = 1'b0;
      for (int k = 0; k < 5; k++) step();
      ioctl_download = 1'b1;
      for (int k = 0; k < 20; k++) step();
      chk("abort cpu_reset", 32'(cpu_reset), 32'h1);
      chk("abort load_done", 32'(load_done), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
